// File: rtl/mod_counter.sv
// Programmable modulo up/down counter with prescaler, parallel load, one-shot
// mode, registered terminal-count pulse and sticky done flag.
module mod_counter #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic             oneshot,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    logic [PRE_W-1:0] pre_cnt;
    logic             run;
    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] next_out;

    // Up-count treats anything at or above limit as terminal so a value
    // loaded above the range wraps immediately; down-count only ends at zero.
    function automatic logic is_terminal(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] lim,
        input logic             up
    );
        if (up)
            return (cnt >= lim);
        else
            return (cnt == '0);
    endfunction

    function automatic logic [WIDTH-1:0] step_value(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] lim,
        input logic             up,
        input logic             term,
        input logic             hold
    );
        logic [WIDTH-1:0] nxt;
        if (term) begin
            if (hold)
                nxt = cnt;
            else if (up)
                nxt = '0;
            else
                nxt = lim;
        end else if (up) begin
            nxt = cnt + 1'b1;
        end else begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

    always_comb begin
        run      = 1'b0;
        tick     = 1'b0;
        terminal = 1'b0;
        next_out = out;
        run      = enable && !done;
        tick     = run && (pre_cnt == prescale);
        terminal = is_terminal(out, limit, up_down);
        next_out = step_value(out, limit, up_down, terminal, oneshot);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            out     <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            out     <= load_val;
            pre_cnt <= '0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (tick) begin
                pre_cnt <= '0;
                out     <= next_out;
                if (terminal) begin
                    tc <= 1'b1;
                    if (oneshot)
                        done <= 1'b1;
                end
            end else if (run) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: directed vectors push hand-computed
// expected state, a monitor on the falling edge pops and compares.
module tb_mod_counter;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             up_down = 1'b1;
    logic [WIDTH-1:0] limit = '1;
    logic             oneshot = 1'b0;
    logic [PRE_W-1:0] prescale = '0;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] o;
        logic             t;
        logic             d;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    mod_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .load(load), .load_val(load_val), .up_down(up_down), .limit(limit),
        .oneshot(oneshot), .prescale(prescale), .out(out), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_now(input string name, input logic [WIDTH-1:0] o,
                             input logic t, input logic d);
        n_checks++;
        if (out !== o || tc !== t || done !== d) begin
            n_fail++;
            $display("FAIL %s: got out=%0d tc=%b done=%b, want out=%0d tc=%b done=%b",
                     name, out, tc, done, o, t, d);
        end
    endtask

    // Monitor: state after each rising edge is compared on the next falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_now(e.name, e.o, e.t, e.d);
            end
        end
    end

    task automatic step(input string name, input logic [WIDTH-1:0] o,
                        input logic t, input logic d);
        exp_t e;
        @(posedge clk);
        #1;
        e.o = o; e.t = t; e.d = d; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1; up_down = 1'b1; limit = 8'd255; prescale = 4'd0; oneshot = 1'b0;

        // Basic full-range count with wrap
        for (int k = 1; k <= 260; k++)
            step("basic_count", WIDTH'(k % 256), (k == 256), 1'b0);

        // Modulo 6 with divide-by-3 prescaler
        clear = 1'b1;
        step("clear", 8'd0, 1'b0, 1'b0);
        clear = 1'b0; limit = 8'd5; prescale = 4'd2;
        for (int k = 1; k <= 40; k++)
            step("modulo_prescale", WIDTH'((k / 3) % 6),
                 (k % 18 == 0), 1'b0);

        // Down count in one-shot mode
        prescale = 4'd0; up_down = 1'b0; oneshot = 1'b1;
        load = 1'b1; load_val = 8'd3;
        step("oneshot_load", 8'd3, 1'b0, 1'b0);
        load = 1'b0;
        step("oneshot_down", 8'd2, 1'b0, 1'b0);
        step("oneshot_down", 8'd1, 1'b0, 1'b0);
        step("oneshot_down", 8'd0, 1'b0, 1'b0);
        step("oneshot_term", 8'd0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++)
            step("oneshot_hold", 8'd0, 1'b0, 1'b1);
        load = 1'b1;
        step("oneshot_reload", 8'd3, 1'b0, 1'b0);
        load = 1'b0;
        step("oneshot_restart", 8'd2, 1'b0, 1'b0);

        // Priority: clear over load over tick, load while disabled, freeze
        oneshot = 1'b0; up_down = 1'b1; limit = 8'd20;
        clear = 1'b1; load = 1'b1; load_val = 8'd9; enable = 1'b1;
        step("clear_over_load", 8'd0, 1'b0, 1'b0);
        clear = 1'b0; enable = 1'b0; prescale = 4'd2;
        step("load_disabled", 8'd9, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        step("pre_advance", 8'd9, 1'b0, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 10; k++)
            step("freeze", 8'd9, 1'b0, 1'b0);
        enable = 1'b1;
        step("resume_pre", 8'd9, 1'b0, 1'b0);
        step("resume_tick", 8'd10, 1'b0, 1'b0);

        // limit = 0: every tick terminal
        prescale = 4'd0; limit = 8'd0;
        clear = 1'b1;
        step("lim0_clear", 8'd0, 1'b0, 1'b0);
        clear = 1'b0;
        for (int k = 0; k < 3; k++)
            step("lim0_tick", 8'd0, 1'b1, 1'b0);

        // Loaded above limit
        limit = 8'd4; load_val = 8'd7; up_down = 1'b1; load = 1'b1;
        step("above_load_up", 8'd7, 1'b0, 1'b0);
        load = 1'b0;
        step("above_up_wrap", 8'd0, 1'b1, 1'b0);
        step("above_up_next", 8'd1, 1'b0, 1'b0);
        up_down = 1'b0; load = 1'b1;
        step("above_load_dn", 8'd7, 1'b0, 1'b0);
        load = 1'b0;
        for (int v = 6; v >= 0; v--)
            step("above_down", WIDTH'(v), 1'b0, 1'b0);
        step("above_down_wrap", 8'd4, 1'b1, 1'b0);
        step("above_down_next", 8'd3, 1'b0, 1'b0);

        // Asynchronous reset between edges with tc and done high
        up_down = 1'b1; oneshot = 1'b1; limit = 8'd4; load_val = 8'd3; load = 1'b1;
        step("pre_rst_load", 8'd3, 1'b0, 1'b0);
        load = 1'b0;
        step("pre_rst_up", 8'd4, 1'b0, 1'b0);
        step("pre_rst_term", 8'd4, 1'b1, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_now("async_reset", 8'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        oneshot = 1'b0; limit = 8'd255;
        step("post_reset", 8'd1, 1'b0, 1'b0);
        step("post_reset", 8'd2, 1'b0, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
